udp_rec: RTL and testbench
==========================

Name: udp_rec

Overview:
- Receive-side UDP stage directly downstream of the IP receiver in the header clipper.
- Consumes the UDP datagram stream (udpsof/udpeof/udpvalidin/udpdatain), checks and strips the 8-byte UDP header, and filters on destination port.
- Forwards only the payload to the application with its own sof/eof/valid framing.
- Reports the source port and flags length mismatches.

Parameters:
- PORT, 16'h0000, accepted destination port; 0 = accept any port.
- MINLEN, 16'd8, minimum legal UDP length field in bytes; smaller values drop the datagram.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- udpsof  input  1  first word of datagram (UDP source port word)
- udpeof  input  1  last word of datagram
- udpvalidin  input  1  udpdatain valid this cycle
- udpdatain  input  16  datagram word
- appsof  output  1  first payload word
- appeof  output  1  last payload word
- appvalid  output  1  appdata valid
- appdata  output  16  payload word
- srcport  output  16  source port of the datagram currently being forwarded
- lenerr  output  1  one-cycle pulse: payload word count did not match the length field
- hdrerr  output  1  one-cycle pulse: datagram ended inside the header, or length field < MINLEN

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0; srcport 0.
  - state IDLE, word counter 0, expected count 0.
- Only cycles with udpvalidin=1 advance the parser. Cycles with udpvalidin=0 hold all state; app outputs deassert that cycle.
- States: IDLE, SRC, DST, LEN, CSUM, PAYLOAD, DROP.
  - IDLE: wait for udpsof=1 with udpvalidin=1. Latch the word as the source port into an internal register, then go to DST. Other words in IDLE are ignored.
  - DST: if PORT!=0 and word!=PORT, go to DROP; else go to LEN.
  - LEN:
    - if word < MINLEN, go to DROP and pulse hdrerr.
    - else expected = (word-8+1)>>1 (17-bit intermediate, no wrap), then go to CSUM.
  - CSUM: checksum word is not verified. Go to PAYLOAD and clear the payload counter.
  - PAYLOAD:
    - each valid word is registered to appdata with appvalid=1 on the next cycle (latency 1).
    - appsof=1 on the first payload word only; srcport updates from the internal latch on that same cycle.
    - counter increments per word, saturating at 16'hFFFF.
    - on udpeof: appeof=1 with that word, and return to IDLE.
    - lenerr pulses on the appeof cycle if counter+1 != expected.
  - DROP: discard words until udpeof, then go to IDLE. No app outputs, no lenerr.
- udpeof while in SRC/DST/LEN/CSUM:
  - pulse hdrerr and return to IDLE.
  - hdrerr is suppressed if the datagram is already being dropped on a port mismatch in that cycle (DST state).
- Expected = 0 (length field exactly 8):
  - an eof arriving at CSUM gives no payload and no lenerr.
  - a payload that appears anyway is forwarded with lenerr at eof.
- A single-word payload gives appsof=1 and appeof=1 in the same cycle.
- udpsof=1 in any state other than IDLE:
  - the current datagram is abandoned and the parser restarts at DST with the new source port.
  - if it was in PAYLOAD, appeof is not generated and hdrerr pulses.
- udpsof and udpeof together on one word: hdrerr pulse, stay in IDLE.
- appsof, appeof, lenerr and hdrerr are single-cycle pulses, cleared on the next clock.
- Reset asserted mid-datagram clears everything immediately. The remainder of that datagram is ignored until the next udpsof.

Test Plan:
- PORT=16'h1F90. Send src=16'h04D2, dst=16'h1F90, len=16'd14, csum=16'h0000, payload 16'hAAAA, 16'hBBBB, 16'hCCCC with eof on the last word.
  -> appvalid for 3 cycles with appdata AAAA/BBBB/CCCC; appsof on AAAA, appeof on CCCC; srcport=04D2; no lenerr.
- Same frame with dst=16'h0050 -> no appvalid, no lenerr, no hdrerr. The next matching frame is forwarded normally.
- len=16'd20 with 3 payload words (expected 6) -> payload forwarded; lenerr pulses on the appeof cycle.
- len=16'd9, one payload word 16'h1234 with eof -> appsof=appeof=1 on the same cycle, appdata=1234, no lenerr.
- Header hazards:
  - eof asserted on the LEN word -> hdrerr pulse, no app output.
  - len=16'd4 -> hdrerr pulse, frame dropped.
- Mid-stream events:
  - a new udpsof arrives after 2 payload words -> hdrerr pulse, no appeof; the new frame is forwarded correctly.
  - reset pulled low during payload -> all outputs 0 immediately.
  - udpvalidin gaps inside payload -> appvalid low during gaps, and the payload word count is unchanged.

Source files
------------

// File: rtl/udp_rec_if.sv
// Streaming bundle between the IP receiver, the UDP stage and the application.
// The slave modport is the UDP stage's view; the master modport drives it.
interface udp_rec_if;
    logic        udpsof;
    logic        udpeof;
    logic        udpvalidin;
    logic [15:0] udpdatain;
    logic        appsof;
    logic        appeof;
    logic        appvalid;
    logic [15:0] appdata;
    logic [15:0] srcport;
    logic        lenerr;
    logic        hdrerr;

    modport slave (
        input  udpsof, udpeof, udpvalidin, udpdatain,
        output appsof, appeof, appvalid, appdata, srcport, lenerr, hdrerr
    );

    modport master (
        output udpsof, udpeof, udpvalidin, udpdatain,
        input  appsof, appeof, appvalid, appdata, srcport, lenerr, hdrerr
    );
endinterface

// File: rtl/udp_rec.sv
// UDP receive stage: strips the 8-byte header, filters on destination port and
// forwards the payload with one cycle of latency plus length/header error pulses.
module udp_rec #(
    parameter logic [15:0] PORT   = 16'h0000,
    parameter logic [15:0] MINLEN = 16'd8
) (
    input  logic      clock,
    input  logic      reset,
    udp_rec_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, SRC, DST, LEN, CSUM, PAYLOAD, DROP
    } state_t;

    state_t      state;
    logic [15:0] srcreg;
    logic [15:0] expected;
    logic [15:0] cnt;

    logic        appsof_p1;
    logic        appeof_p1;
    logic        vld_p1;
    logic [15:0] appdata_p1;
    logic [15:0] srcport_p1;
    logic        lenerr_p1;
    logic        hdrerr_p1;

    logic [15:0] word;
    logic        portmiss;
    assign word     = bus.udpdatain;
    assign portmiss = (PORT != 16'h0000) && (word != PORT);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Payload words expected for a length field; word-7 cannot wrap once word >= 8.
    function automatic logic [15:0] len_to_words(input logic [15:0] len);
        return (len < 16'd8) ? 16'd0 : ((len - 16'd7) >> 1);
    endfunction

    // Stage p0 -> p1: parse the incoming word and register the app outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            srcreg     <= 16'd0;
            expected   <= 16'd0;
            cnt        <= 16'd0;
            appsof_p1  <= 1'b0;
            appeof_p1  <= 1'b0;
            vld_p1     <= 1'b0;
            appdata_p1 <= 16'd0;
            srcport_p1 <= 16'd0;
            lenerr_p1  <= 1'b0;
            hdrerr_p1  <= 1'b0;
        end else begin
            appsof_p1 <= 1'b0;
            appeof_p1 <= 1'b0;
            vld_p1    <= 1'b0;
            lenerr_p1 <= 1'b0;
            hdrerr_p1 <= 1'b0;
            if (bus.udpvalidin) begin
                if (bus.udpsof) begin
                    if (bus.udpeof) begin
                        hdrerr_p1 <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        srcreg    <= word;
                        state     <= DST;
                        hdrerr_p1 <= (state == PAYLOAD);
                    end
                end else begin
                    case (state)
                        DST: begin
                            if (bus.udpeof) begin
                                hdrerr_p1 <= !portmiss;
                                state     <= IDLE;
                            end else begin
                                state <= portmiss ? DROP : LEN;
                            end
                        end
                        LEN: begin
                            if (bus.udpeof) begin
                                hdrerr_p1 <= 1'b1;
                                state     <= IDLE;
                            end else if (word < MINLEN) begin
                                hdrerr_p1 <= 1'b1;
                                state     <= DROP;
                            end else begin
                                expected <= len_to_words(word);
                                state    <= CSUM;
                            end
                        end
                        CSUM: begin
                            cnt <= 16'd0;
                            if (bus.udpeof) begin
                                hdrerr_p1 <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                        PAYLOAD: begin
                            vld_p1     <= 1'b1;
                            appdata_p1 <= word;
                            appsof_p1  <= (cnt == 16'd0);
                            if (cnt == 16'd0)
                                srcport_p1 <= srcreg;
                            cnt <= sat_inc(cnt);
                            if (bus.udpeof) begin
                                appeof_p1 <= 1'b1;
                                lenerr_p1 <= (({1'b0, cnt} + 17'd1) != {1'b0, expected});
                                state     <= IDLE;
                            end
                        end
                        DROP: begin
                            if (bus.udpeof)
                                state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.appsof   = appsof_p1;
    assign bus.appeof   = appeof_p1;
    assign bus.appvalid = vld_p1;
    assign bus.appdata  = appdata_p1;
    assign bus.srcport  = srcport_p1;
    assign bus.lenerr   = lenerr_p1;
    assign bus.hdrerr   = hdrerr_p1;
endmodule

// File: tb/tb_udp_rec.sv
// Bench for udp_rec: frame table plus hand sequences, payload scoreboard queue.
module tb_udp_rec;
    localparam logic [15:0] PORT = 16'h1F90;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    udp_rec_if bus ();
    udp_rec #(.PORT(PORT), .MINLEN(16'd8)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic        lenerr;
        logic [15:0] data;
        logic [15:0] src;
    } exp_t;

    typedef struct {
        logic [15:0]       src;
        logic [15:0]       dst;
        logic [15:0]       len;
        int                npay;
        logic [3:0][15:0]  pay;
        bit                fwd;
        bit                elen;
        int                ehdr;
    } vec_t;

    exp_t q[$];
    vec_t tbl[7];
    int   total = 0;
    int   bad   = 0;
    int   hdr_cnt = 0;
    int   hdr0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Output monitor on the falling edge, away from the registering edge.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.hdrerr) hdr_cnt++;
            if (bus.appvalid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_appvalid: got data %h want no word", bus.appdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("appdata", {16'd0, bus.appdata}, {16'd0, e.data});
                    chk("appsof",  {31'd0, bus.appsof},  {31'd0, e.sof});
                    chk("appeof",  {31'd0, bus.appeof},  {31'd0, e.eof});
                    chk("lenerr",  {31'd0, bus.lenerr},  {31'd0, e.lenerr});
                    chk("srcport", {16'd0, bus.srcport}, {16'd0, e.src});
                end
            end else begin
                chk("lenerr_noword", {31'd0, bus.lenerr}, 32'd0);
                chk("appsof_noword", {31'd0, bus.appsof}, 32'd0);
            end
        end
    end

    task automatic send_word(input logic sof, input logic eof, input logic [15:0] d);
        bus.udpsof     = sof;
        bus.udpeof     = eof;
        bus.udpvalidin = 1'b1;
        bus.udpdatain  = d;
        @(posedge clock);
        #1;
        bus.udpvalidin = 1'b0;
        bus.udpsof     = 1'b0;
        bus.udpeof     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                              input int npay, input logic [3:0][15:0] pay, input bit fwd, input bit elen);
        send_word(1'b1, 1'b0, src);
        send_word(1'b0, 1'b0, dst);
        send_word(1'b0, 1'b0, len);
        send_word(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < npay; i++) begin
            if (fwd) q.push_back({(i == 0), (i == npay - 1), (elen && i == npay - 1), pay[i], src});
            send_word(1'b0, (i == npay - 1), pay[i]);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_appvalid"}, {31'd0, bus.appvalid}, 32'd0);
        chk({name, "_appsof"},   {31'd0, bus.appsof},   32'd0);
        chk({name, "_appeof"},   {31'd0, bus.appeof},   32'd0);
        chk({name, "_appdata"},  {16'd0, bus.appdata},  32'd0);
        chk({name, "_srcport"},  {16'd0, bus.srcport},  32'd0);
        chk({name, "_lenerr"},   {31'd0, bus.lenerr},   32'd0);
        chk({name, "_hdrerr"},   {31'd0, bus.hdrerr},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'h04D2, 16'h1F90, 16'd14, 3, {16'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 1'b1, 1'b0, 0};
        tbl[1] = '{16'h04D2, 16'h0050, 16'd14, 3, {16'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 1'b0, 1'b0, 0};
        tbl[2] = '{16'h1111, 16'h1F90, 16'd14, 3, {16'h0, 16'h0003, 16'h0002, 16'h0001}, 1'b1, 1'b0, 0};
        tbl[3] = '{16'h2222, 16'h1F90, 16'd20, 3, {16'h0, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 1'b1, 0};
        tbl[4] = '{16'h3333, 16'h1F90, 16'd9,  1, {16'h0, 16'h0, 16'h0, 16'h1234},       1'b1, 1'b0, 0};
        tbl[5] = '{16'h4444, 16'h1F90, 16'd4,  2, {16'h0, 16'h0, 16'h5678, 16'h9ABC},    1'b0, 1'b0, 1};
        tbl[6] = '{16'h5555, 16'h1F90, 16'd8,  1, {16'h0, 16'h0, 16'h0, 16'h5555},       1'b1, 1'b1, 0};

        bus.udpsof = 1'b0; bus.udpeof = 1'b0; bus.udpvalidin = 1'b0; bus.udpdatain = 16'h0;
        #12;
        check_outputs_zero("reset");
        reset = 1'b1;
        idle(2);

        for (int t = 0; t < 7; t++) begin
            hdr0 = hdr_cnt;
            send_frame(tbl[t].src, tbl[t].dst, tbl[t].len, tbl[t].npay, tbl[t].pay, tbl[t].fwd, tbl[t].elen);
            idle(2);
            chk($sformatf("hdrerr_row%0d", t), hdr_cnt - hdr0, tbl[t].ehdr);
            chk($sformatf("drained_row%0d", t), q.size(), 0);
        end

        // eof on the length word ends the datagram inside the header
        hdr0 = hdr_cnt;
        send_word(1'b1, 1'b0, 16'h0A0A);
        send_word(1'b0, 1'b0, PORT);
        send_word(1'b0, 1'b1, 16'd14);
        idle(2);
        chk("hdrerr_eof_len", hdr_cnt - hdr0, 1);

        // sof and eof on the same word
        hdr0 = hdr_cnt;
        send_word(1'b1, 1'b1, 16'h0B0B);
        idle(2);
        chk("hdrerr_sof_eof", hdr_cnt - hdr0, 1);

        // new sof after two payload words abandons the datagram without appeof
        hdr0 = hdr_cnt;
        send_word(1'b1, 1'b0, 16'h0C0C);
        send_word(1'b0, 1'b0, PORT);
        send_word(1'b0, 1'b0, 16'd14);
        send_word(1'b0, 1'b0, 16'h0000);
        q.push_back({1'b1, 1'b0, 1'b0, 16'hD001, 16'h0C0C});
        send_word(1'b0, 1'b0, 16'hD001);
        q.push_back({1'b0, 1'b0, 1'b0, 16'hD002, 16'h0C0C});
        send_word(1'b0, 1'b0, 16'hD002);
        send_frame(16'h0D0D, PORT, 16'd14, 3, {16'h0, 16'hE003, 16'hE002, 16'hE001}, 1'b1, 1'b0);
        idle(2);
        chk("hdrerr_restart", hdr_cnt - hdr0, 1);
        chk("drained_restart", q.size(), 0);

        // valid gaps inside the payload
        send_word(1'b1, 1'b0, 16'h0E0E);
        send_word(1'b0, 1'b0, PORT);
        send_word(1'b0, 1'b0, 16'd14);
        send_word(1'b0, 1'b0, 16'h0000);
        q.push_back({1'b1, 1'b0, 1'b0, 16'hF001, 16'h0E0E});
        send_word(1'b0, 1'b0, 16'hF001);
        idle(1);
        chk("gap_appvalid", {31'd0, bus.appvalid}, 32'd0);
        q.push_back({1'b0, 1'b0, 1'b0, 16'hF002, 16'h0E0E});
        send_word(1'b0, 1'b0, 16'hF002);
        idle(3);
        chk("gap2_appvalid", {31'd0, bus.appvalid}, 32'd0);
        q.push_back({1'b0, 1'b1, 1'b0, 16'hF003, 16'h0E0E});
        send_word(1'b0, 1'b1, 16'hF003);
        idle(2);
        chk("drained_gap", q.size(), 0);

        // reset during payload clears outputs at once; the tail is ignored
        hdr0 = hdr_cnt;
        send_word(1'b1, 1'b0, 16'h0F0F);
        send_word(1'b0, 1'b0, PORT);
        send_word(1'b0, 1'b0, 16'd14);
        send_word(1'b0, 1'b0, 16'h0000);
        send_word(1'b0, 1'b0, 16'h7001);
        reset = 1'b0;
        #1;
        check_outputs_zero("midreset");
        idle(1);
        reset = 1'b1;
        send_word(1'b0, 1'b0, 16'h7002);
        send_word(1'b0, 1'b1, 16'h7003);
        idle(2);
        chk("hdrerr_after_reset", hdr_cnt - hdr0, 0);
        send_frame(16'h0123, PORT, 16'd10, 2, {16'h0, 16'h0, 16'h8002, 16'h8001}, 1'b1, 1'b1);
        idle(2);
        chk("drained_final", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
